// File: rtl/data_tape.sv
// Data-tape memory for the processor core: a pointer-addressed RAM with a cached current cell.
// The core issues ADD/MOVE/WRITE/READ operations instead of raw addresses.
module data_tape #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 15,
    parameter int DELTA_WIDTH    = 8,
    parameter int CLEAR_ON_RESET = 1,
    parameter int WRAP_POINTER   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             op,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [DELTA_WIDTH-1:0] delta,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   cell_zero,
    output logic [ADDR_WIDTH-1:0]  pointer,
    output logic                   ptr_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Pointer arithmetic is kept wide enough that no MOVE delta can alias back into range.
    localparam int SUM_W = ((ADDR_WIDTH + 1 > DELTA_WIDTH) ? ADDR_WIDTH + 1 : DELTA_WIDTH) + 1;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_MOVE  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_FETCH = 2'd1,
        ST_IDLE  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pointer_q, pointer_d;
    logic [ADDR_WIDTH-1:0]   clear_cnt_q, clear_cnt_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    ptr_err_q, ptr_err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;

    logic                    accept;
    logic [DATA_WIDTH-1:0]   delta_data;
    logic [DATA_WIDTH-1:0]   add_value;
    logic [SUM_W-1:0]        ptr_sum;
    logic                    ptr_under;
    logic                    ptr_over;

    assign accept = op_valid && (state_q == ST_IDLE);

    if (DELTA_WIDTH >= DATA_WIDTH) begin : g_delta_trunc
        assign delta_data = delta[DATA_WIDTH-1:0];
    end else begin : g_delta_ext
        assign delta_data = {{(DATA_WIDTH - DELTA_WIDTH){delta[DELTA_WIDTH-1]}}, delta};
    end

    assign add_value = data_out_q + delta_data;
    assign ptr_sum   = {{(SUM_W - ADDR_WIDTH){1'b0}}, pointer_q}
                     + {{(SUM_W - DELTA_WIDTH){delta[DELTA_WIDTH-1]}}, delta};
    assign ptr_under = ptr_sum[SUM_W-1];
    assign ptr_over  = !ptr_sum[SUM_W-1] && (ptr_sum[SUM_W-2:ADDR_WIDTH] != '0);

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        pointer_q   <= pointer_d;
        clear_cnt_q <= clear_cnt_d;
        data_out_q  <= data_out_d;
        ptr_err_q   <= ptr_err_d;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_FETCH;
        end else begin
            unique case (state_q)
                ST_CLEAR: if (clear_cnt_q == '1) state_d = ST_IDLE;
                ST_FETCH: state_d = ST_IDLE;
                ST_IDLE:  if (accept && (op == OP_MOVE || op == OP_READ)) state_d = ST_FETCH;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pointer_d   = pointer_q;
        clear_cnt_d = clear_cnt_q;
        data_out_d  = data_out_q;
        ptr_err_d   = ptr_err_q;
        ram_we      = 1'b0;
        ram_addr    = pointer_q;
        ram_wdata   = '0;
        if (reset) begin
            pointer_d   = '0;
            clear_cnt_d = '0;
            data_out_d  = '0;
            ptr_err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ram_we      = 1'b1;
                    ram_addr    = clear_cnt_q;
                    clear_cnt_d = clear_cnt_q + ADDR_WIDTH'(1);
                end
                ST_FETCH: data_out_d = mem[pointer_q];
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_ADD: begin
                                ram_we     = 1'b1;
                                ram_wdata  = add_value;
                                data_out_d = add_value;
                            end
                            OP_WRITE: begin
                                ram_we     = 1'b1;
                                ram_wdata  = data_in;
                                data_out_d = data_in;
                            end
                            OP_MOVE: begin
                                if (WRAP_POINTER != 0) begin
                                    pointer_d = ptr_sum[ADDR_WIDTH-1:0];
                                end else if (ptr_under) begin
                                    pointer_d = '0;
                                    ptr_err_d = 1'b1;
                                end else if (ptr_over) begin
                                    pointer_d = '1;
                                    ptr_err_d = 1'b1;
                                end else begin
                                    pointer_d = ptr_sum[ADDR_WIDTH-1:0];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        op_ready  = (state_q == ST_IDLE);
        data_out  = data_out_q;
        cell_zero = (data_out_q == '0);
        pointer   = pointer_q;
        ptr_err   = ptr_err_q;
    end

endmodule

// File: tb/tb_data_tape.sv
// Testbench for data_tape: a wrapping/clearing instance and a saturating/non-clearing instance
// run the same operation stream and are compared against a behavioural tape model.
module tb_data_tape;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DLW   = 8;
    localparam int DEPTH = 16;

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_MOVE  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    op;
    logic          op_valid;
    logic [DLW-1:0] delta;
    logic [DW-1:0] data_in;

    logic          rdy  [2];
    logic [DW-1:0] dout [2];
    logic          zero [2];
    logic [AW-1:0] ptr  [2];
    logic          err  [2];

    int errors = 0;
    int checks = 0;

    // Reference tape: index 0 wraps and clears on reset, index 1 saturates and keeps contents.
    logic [DW-1:0] tape_m [2][DEPTH];
    int            ptr_m  [2];
    logic          err_m  [2];
    logic [DW-1:0] dout_m [2];

    always #5 clk = ~clk;

    data_tape #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DELTA_WIDTH(DLW),
        .CLEAR_ON_RESET(1), .WRAP_POINTER(1)
    ) dut_wrap (
        .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .op_ready(rdy[0]),
        .delta(delta), .data_in(data_in), .data_out(dout[0]), .cell_zero(zero[0]),
        .pointer(ptr[0]), .ptr_err(err[0])
    );

    data_tape #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DELTA_WIDTH(DLW),
        .CLEAR_ON_RESET(0), .WRAP_POINTER(0)
    ) dut_sat (
        .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .op_ready(rdy[1]),
        .delta(delta), .data_in(data_in), .data_out(dout[1]), .cell_zero(zero[1]),
        .pointer(ptr[1]), .ptr_err(err[1])
    );

    function automatic void model_op(int k, logic [1:0] o, logic [7:0] d8, logic [7:0] din);
        int d;
        int p;
        d = int'($signed(d8));
        case (o)
            OP_ADD: begin
                dout_m[k] = 8'(int'(dout_m[k]) + d);
                tape_m[k][ptr_m[k]] = dout_m[k];
            end
            OP_WRITE: begin
                dout_m[k] = din;
                tape_m[k][ptr_m[k]] = din;
            end
            OP_MOVE: begin
                p = ptr_m[k] + d;
                if (k == 0) ptr_m[k] = ((p % DEPTH) + DEPTH) % DEPTH;
                else if (p < 0) begin ptr_m[k] = 0; err_m[k] = 1'b1; end
                else if (p > DEPTH - 1) begin ptr_m[k] = DEPTH - 1; err_m[k] = 1'b1; end
                else ptr_m[k] = p;
                dout_m[k] = tape_m[k][ptr_m[k]];
            end
            default: dout_m[k] = tape_m[k][ptr_m[k]];
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            ptr_m[k] = 0;
            err_m[k] = 1'b0;
        end
        for (int a = 0; a < DEPTH; a++) tape_m[0][a] = '0;
        dout_m[0] = '0;
        dout_m[1] = tape_m[1][0];
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!(rdy[0] && rdy[1]) && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(rdy[0] && rdy[1])) begin
            errors++;
            $display("[TB] FAIL ready_timeout: op_ready=%b/%b required 1/1", rdy[0], rdy[1]);
        end
    endtask

    task automatic release_reset(output int c0, output int c1);
        reset = 1'b0;
        c0 = 0;
        c1 = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy[0] && c0 == 0) c0 = n;
            if (rdy[1] && c1 == 0) c1 = n;
            if (c0 != 0 && c1 != 0) break;
        end
        model_reset();
    endtask

    task automatic apply_reset();
        int c0, c1;
        reset    = 1'b1;
        op_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        release_reset(c0, c1);
        wait_ready();
    endtask

    task automatic issue(logic [1:0] o, logic [7:0] d, logic [7:0] din);
        wait_ready();
        op       = o;
        delta    = d;
        data_in  = din;
        op_valid = 1'b1;
        @(posedge clk);
        model_op(0, o, d, din);
        model_op(1, o, d, din);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        int c0, c1;
        reset = 1'b1; op_valid = 1'b0; op = '0; delta = '0; data_in = '0;
        for (int a = 0; a < DEPTH; a++) begin tape_m[0][a] = '0; tape_m[1][a] = 'x; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks += 5;
            if (rdy[k] !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ready[%0d]: got %b want 0", k, rdy[k]); end
            if (dout[k] !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout[%0d]: got %h want 00", k, dout[k]); end
            if (zero[k] !== 1'b1)  begin errors++; $display("[TB] FAIL reset_zero[%0d]: got %b want 1", k, zero[k]); end
            if (ptr[k] !== 4'd0)   begin errors++; $display("[TB] FAIL reset_ptr[%0d]: got %0d want 0", k, ptr[k]); end
            if (err[k] !== 1'b0)   begin errors++; $display("[TB] FAIL reset_err[%0d]: got %b want 0", k, err[k]); end
        end
        release_reset(c0, c1);
        checks += 2;
        if (c0 != DEPTH) begin errors++; $display("[TB] FAIL clear_latency: got %0d cycles want %0d", c0, DEPTH); end
        if (c1 != 1)     begin errors++; $display("[TB] FAIL fetch_latency: got %0d cycles want 1", c1); end
    endtask

    task automatic test_clear_sweep();
        int c0, c1;
        for (int i = 0; i < DEPTH; i++) begin
            issue(OP_WRITE, 8'd0, 8'hAA);
            issue(OP_MOVE, 8'd1, 8'd0);
        end
        wait_ready();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        release_reset(c0, c1);
        checks++;
        if (c0 != DEPTH) begin errors++; $display("[TB] FAIL sweep_latency: got %0d want %0d", c0, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            wait_ready();
            checks += 3;
            if (dout[0] !== 8'h00) begin errors++; $display("[TB] FAIL sweep_dout cell %0d: got %h want 00", i, dout[0]); end
            if (zero[0] !== 1'b1)  begin errors++; $display("[TB] FAIL sweep_zero cell %0d: got %b want 1", i, zero[0]); end
            if (dout[1] !== dout_m[1]) begin errors++; $display("[TB] FAIL keep_dout cell %0d: got %h want %h", i, dout[1], dout_m[1]); end
            issue(OP_MOVE, 8'd1, 8'd0);
        end
        wait_ready();
    endtask

    task automatic test_add_wrap();
        apply_reset();
        issue(OP_WRITE, 8'd0, 8'hFF);
        issue(OP_ADD, 8'd1, 8'd0);
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (dout[k] !== 8'h00) begin errors++; $display("[TB] FAIL add_wrap[%0d]: got %h want 00", k, dout[k]); end
            if (zero[k] !== 1'b1)  begin errors++; $display("[TB] FAIL add_zero[%0d]: got %b want 1", k, zero[k]); end
        end
        issue(OP_ADD, 8'hFE, 8'd0);
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (dout[k] !== 8'hFE) begin errors++; $display("[TB] FAIL add_neg[%0d]: got %h want FE", k, dout[k]); end
            if (zero[k] !== 1'b0)  begin errors++; $display("[TB] FAIL add_nonzero[%0d]: got %b want 0", k, zero[k]); end
        end
    endtask

    task automatic test_back_to_back();
        wait_ready();
        op = OP_ADD; delta = 8'd1; data_in = '0; op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!(rdy[0] && rdy[1])) begin errors++; $display("[TB] FAIL b2b_ready step %0d: got %b/%b want 1/1", i, rdy[0], rdy[1]); end
            @(posedge clk);
            model_op(0, OP_ADD, 8'd1, 8'd0);
            model_op(1, OP_ADD, 8'd1, 8'd0);
            @(negedge clk);
        end
        op_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (dout[k] !== 8'h01)     begin errors++; $display("[TB] FAIL b2b_dout[%0d]: got %h want 01", k, dout[k]); end
            if (dout[k] !== dout_m[k]) begin errors++; $display("[TB] FAIL b2b_model[%0d]: got %h want %h", k, dout[k], dout_m[k]); end
        end
    endtask

    task automatic test_move_latency();
        apply_reset();
        issue(OP_WRITE, 8'd0, 8'h55);
        issue(OP_MOVE, 8'd3, 8'd0);
        for (int k = 0; k < 2; k++) begin
            checks += 2;
            if (ptr[k] !== 4'd3)  begin errors++; $display("[TB] FAIL move_ptr[%0d]: got %0d want 3", k, ptr[k]); end
            if (rdy[k] !== 1'b0)  begin errors++; $display("[TB] FAIL fetch_busy[%0d]: got %b want 0", k, rdy[k]); end
        end
        @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (!(rdy[0] && rdy[1])) begin errors++; $display("[TB] FAIL fetch_done: got %b/%b want 1/1", rdy[0], rdy[1]); end
        if (dout[0] !== 8'h00)     begin errors++; $display("[TB] FAIL move_dout: got %h want 00", dout[0]); end
        if (dout[1] !== dout_m[1]) begin errors++; $display("[TB] FAIL move_dout_sat: got %h want %h", dout[1], dout_m[1]); end
        issue(OP_MOVE, 8'hFD, 8'd0);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout[k] !== 8'h55) begin errors++; $display("[TB] FAIL move_back[%0d]: got %h want 55", k, dout[k]); end
        end
    endtask

    task automatic test_pointer_wrap();
        apply_reset();
        issue(OP_MOVE, 8'hFF, 8'd0);
        wait_ready();
        checks += 4;
        if (ptr[0] !== 4'd15) begin errors++; $display("[TB] FAIL wrap_neg: got %0d want 15", ptr[0]); end
        if (err[0] !== 1'b0)  begin errors++; $display("[TB] FAIL wrap_err: got %b want 0", err[0]); end
        if (ptr[1] !== 4'd0)  begin errors++; $display("[TB] FAIL sat_low: got %0d want 0", ptr[1]); end
        if (err[1] !== 1'b1)  begin errors++; $display("[TB] FAIL sat_low_err: got %b want 1", err[1]); end
        issue(OP_MOVE, 8'd2, 8'd0);
        wait_ready();
        checks += 3;
        if (ptr[0] !== 4'd1) begin errors++; $display("[TB] FAIL wrap_pos: got %0d want 1", ptr[0]); end
        if (err[0] !== 1'b0) begin errors++; $display("[TB] FAIL wrap_err2: got %b want 0", err[0]); end
        if (ptr[1] !== 4'd2) begin errors++; $display("[TB] FAIL sat_step: got %0d want 2", ptr[1]); end
    endtask

    task automatic test_pointer_saturate();
        apply_reset();
        issue(OP_MOVE, 8'd14, 8'd0);
        issue(OP_MOVE, 8'd5, 8'd0);
        wait_ready();
        checks += 3;
        if (ptr[1] !== 4'd15) begin errors++; $display("[TB] FAIL sat_high: got %0d want 15", ptr[1]); end
        if (err[1] !== 1'b1)  begin errors++; $display("[TB] FAIL sat_high_err: got %b want 1", err[1]); end
        if (ptr[0] !== 4'd3)  begin errors++; $display("[TB] FAIL wrap_high: got %0d want 3", ptr[0]); end
        issue(OP_MOVE, 8'hEC, 8'd0);
        wait_ready();
        checks += 3;
        if (ptr[1] !== 4'd0)  begin errors++; $display("[TB] FAIL sat_low2: got %0d want 0", ptr[1]); end
        if (err[1] !== 1'b1)  begin errors++; $display("[TB] FAIL err_sticky: got %b want 1", err[1]); end
        if (ptr[0] !== 4'(ptr_m[0])) begin errors++; $display("[TB] FAIL wrap_low: got %0d want %0d", ptr[0], ptr_m[0]); end
        apply_reset();
        checks++;
        if (err[1] !== 1'b0) begin errors++; $display("[TB] FAIL err_reset: got %b want 0", err[1]); end
    endtask

    task automatic test_reset_mid_op();
        int c0, c1;
        apply_reset();
        issue(OP_MOVE, 8'd2, 8'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (ptr[k] !== 4'd0)   begin errors++; $display("[TB] FAIL midfetch_ptr[%0d]: got %0d want 0", k, ptr[k]); end
            if (dout[k] !== 8'h00) begin errors++; $display("[TB] FAIL midfetch_dout[%0d]: got %h want 00", k, dout[k]); end
            if (rdy[k] !== 1'b0)   begin errors++; $display("[TB] FAIL midfetch_ready[%0d]: got %b want 0", k, rdy[k]); end
        end
        release_reset(c0, c1);
        checks++;
        if (c0 != DEPTH) begin errors++; $display("[TB] FAIL midfetch_clear: got %0d want %0d", c0, DEPTH); end
        issue(OP_WRITE, 8'd0, 8'h10);
        wait_ready();
        op = OP_ADD; delta = 8'd5; op_valid = 1'b1; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        checks += 2;
        if (dout[0] !== 8'h00) begin errors++; $display("[TB] FAIL midadd_dout0: got %h want 00", dout[0]); end
        if (dout[1] !== 8'h00) begin errors++; $display("[TB] FAIL midadd_dout1: got %h want 00", dout[1]); end
        release_reset(c0, c1);
        wait_ready();
        checks += 2;
        if (dout[1] !== 8'h10) begin errors++; $display("[TB] FAIL add_discarded: got %h want 10", dout[1]); end
        if (dout[0] !== 8'h00) begin errors++; $display("[TB] FAIL add_cleared: got %h want 00", dout[0]); end
        issue(OP_READ, 8'd0, 8'd0);
        wait_ready();
        checks++;
        if (dout[1] !== 8'h10) begin errors++; $display("[TB] FAIL read_back: got %h want 10", dout[1]); end
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [7:0] d, din;
        for (int i = 0; i < 80; i++) begin
            o   = 2'($urandom_range(0, 3));
            d   = 8'($urandom_range(0, 32) - 16);
            din = 8'($urandom_range(0, 255));
            issue(o, d, din);
            wait_ready();
            for (int k = 0; k < 2; k++) begin
                checks += 4;
                if (dout[k] !== dout_m[k]) begin errors++; $display("[TB] FAIL rnd_dout[%0d] op %0d: got %h want %h", k, i, dout[k], dout_m[k]); end
                if (zero[k] !== (dout_m[k] == 8'h00)) begin errors++; $display("[TB] FAIL rnd_zero[%0d] op %0d: got %b want %b", k, i, zero[k], dout_m[k] == 8'h00); end
                if (ptr[k] !== 4'(ptr_m[k])) begin errors++; $display("[TB] FAIL rnd_ptr[%0d] op %0d: got %0d want %0d", k, i, ptr[k], ptr_m[k]); end
                if (err[k] !== err_m[k])   begin errors++; $display("[TB] FAIL rnd_err[%0d] op %0d: got %b want %b", k, i, err[k], err_m[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_add_wrap();
        test_back_to_back();
        test_move_latency();
        test_pointer_wrap();
        test_pointer_saturate();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
